detector_jogada: RTL

Input-conditioning stage that sits directly upstream of the game datapath and control unit. It synchronises and debounces the four player keys (chaves). It emits exactly one single-cycle jogada_feita pulse per valid single-key press, together with a registered one-hot code of the key. Multi-key presses are rejected with a separate pulse, so the control unit only ever sees clean, one-hot plays.

---
 rtl/detector_jogada.sv | 89 ++++++++
 1 files changed

// File: rtl/detector_jogada.sv
// detector_jogada: synchronises and debounces four player keys and emits clean one-hot plays.
// Multi-key presses raise multipla instead. Every press must be released and debounced before the next one.
module detector_jogada #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_W = 16
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       habilita,
   input  logic [3:0] chaves,
   output logic       jogada_feita,
   output logic [3:0] jogada,
   output logic       multipla,
   output logic [3:0] db_estado
);
   typedef enum logic [2:0] {
      ESPERA   = 3'd0,
      FILTRA   = 3'd1,
      EMITE    = 3'd2,
      INVALIDA = 3'd3,
      SOLTA    = 3'd4
   } estado_t;
   estado_t          estado;
   logic [3:0]       meta;
   logic [3:0]       sync;
   logic [3:0]       amostra;
   logic [CNT_W-1:0] cnt;
   logic             fim;
   logic             um_quente;
   assign fim       = cnt == CNT_W'(DEBOUNCE_CYCLES - 1);
   assign um_quente = (amostra & (amostra - 4'd1)) == 4'd0;
   assign db_estado = {1'b0, estado};
   // Pulses are set on the edge that enters EMITE/INVALIDA, so they are high exactly in that state.
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         meta         <= '0;
         sync         <= '0;
         estado       <= SOLTA;
         cnt          <= '0;
         amostra      <= '0;
         jogada       <= '0;
         jogada_feita <= 1'b0;
         multipla     <= 1'b0;
      end else begin
         meta         <= chaves;
         sync         <= meta;
         jogada_feita <= 1'b0;
         multipla     <= 1'b0;
         case (estado)
            ESPERA:
               if (habilita && sync != 4'd0) begin
                  estado  <= FILTRA;
                  amostra <= sync;
                  cnt     <= '0;
               end
            FILTRA:
               if (!habilita) begin
                  estado <= SOLTA;
                  cnt    <= '0;
               end else if (sync == 4'd0)
                  estado <= ESPERA;
               else if (sync != amostra) begin
                  amostra <= sync;
                  cnt     <= '0;
               end else if (fim) begin
                  if (um_quente) begin
                     estado       <= EMITE;
                     jogada       <= amostra;
                     jogada_feita <= 1'b1;
                  end else begin
                     estado   <= INVALIDA;
                     multipla <= 1'b1;
                  end
               end else
                  cnt <= cnt + 1'b1;
            EMITE, INVALIDA: begin
               estado <= SOLTA;
               cnt    <= '0;
            end
            default:
               if (sync != 4'd0)
                  cnt <= '0;
               else if (fim)
                  estado <= ESPERA;
               else
                  cnt <= cnt + 1'b1;
         endcase
      end
endmodule
